// File: rtl/sprite_drawer_pkg.sv
// sprite_drawer_pkg: shared graphics constants, drawer encodings and built-in sprite art
package sprite_drawer_pkg;
    localparam int SCREEN_W = 320;
    localparam int SCREEN_H = 240;
    localparam int COLOUR_W = 9;
    typedef enum logic {MODE_CHAR = 1'b0, MODE_BG = 1'b1} mode_t;
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_DRAW = 2'd1, S_FLUSH = 2'd2, S_DONE = 2'd3} state_t;
    // Character art: the left column is see-through, every other pixel is a colour ramp
    function automatic logic [COLOUR_W-1:0] sprite_pixel(input int unsigned addr, input int unsigned width,
                                                         input logic [COLOUR_W-1:0] transparent);
        logic [COLOUR_W-1:0] c;
        c = COLOUR_W'(32'h40 + addr);
        return (addr % width == 0) ? transparent : c;
    endfunction
endpackage

// File: rtl/sprite_drawer_rom.sv
// sprite_rom: synchronous one-cycle character ROM holding SPRITE_W*SPRITE_H colours
module sprite_rom
    import sprite_drawer_pkg::*;
#(
    parameter int SPRITE_W = 8,
    parameter int SPRITE_H = 8,
    parameter logic [COLOUR_W-1:0] TRANSPARENT = 9'h1FF,
    parameter int AW = (SPRITE_W * SPRITE_H > 1) ? $clog2(SPRITE_W * SPRITE_H) : 1
)(
    input  logic                clock,
    input  logic [AW-1:0]       i_addr,
    output logic [COLOUR_W-1:0] o_data
);
    logic [COLOUR_W-1:0] r_data;
    // Registered read so the colour lines up with the external background ROM latency
    always_ff @(posedge clock) begin
        r_data <= sprite_pixel(32'(i_addr), SPRITE_W, TRANSPARENT);
    end
    assign o_data = r_data;
endmodule

// File: rtl/sprite_drawer.sv
// sprite_drawer: scans a sprite-sized box and plots either character art or restored background
module sprite_drawer
    import sprite_drawer_pkg::*;
#(
    parameter int SPRITE_W = 8,
    parameter int SPRITE_H = 8,
    parameter logic [8:0] TRANSPARENT = 9'h1FF
)(
    input  logic        clock,
    input  logic        resetn,
    input  logic        drawChar,
    input  logic        drawBG,
    input  logic [8:0]  xCoordinate,
    input  logic [7:0]  yCoordinate,
    output logic        doneChar,
    output logic        doneBG,
    output logic [16:0] bg_addr,
    input  logic [8:0]  bg_data,
    output logic [8:0]  vga_x,
    output logic [7:0]  vga_y,
    output logic [8:0]  colour,
    output logic        plot
);
    localparam int CXW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
    localparam int CYW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
    localparam int AW  = (SPRITE_W * SPRITE_H > 1) ? $clog2(SPRITE_W * SPRITE_H) : 1;

    state_t          r_state, w_next;
    mode_t           r_mode;
    logic            r_req_char, r_req_bg;
    logic [8:0]      r_x;
    logic [7:0]      r_y;
    logic [CXW-1:0]  r_cx;
    logic [CYW-1:0]  r_cy;
    logic            r_pv, r_pon;
    logic [8:0]      r_px;
    logic [7:0]      r_py;
    logic            w_bg_rise, w_char_rise, w_start, w_last, w_on, w_cx_end;
    logic [9:0]      w_x;
    logic [8:0]      w_y;
    logic [AW-1:0]   w_rom_addr;
    logic [8:0]      w_rom_data;

    assign w_bg_rise   = drawBG & ~r_req_bg;
    assign w_char_rise = drawChar & ~r_req_char;
    assign w_start     = (r_state == S_IDLE) & (w_bg_rise | w_char_rise);
    assign w_cx_end    = r_cx == CXW'(SPRITE_W - 1);
    assign w_last      = w_cx_end & (r_cy == CYW'(SPRITE_H - 1));
    assign w_x         = {1'b0, r_x} + 10'(r_cx);
    assign w_y         = {1'b0, r_y} + 9'(r_cy);
    assign w_on        = (w_x < 10'(SCREEN_W)) & (w_y < 9'(SCREEN_H));
    assign w_rom_addr  = AW'(r_cy) * AW'(SPRITE_W) + AW'(r_cx);

    sprite_rom #(
        .SPRITE_W    (SPRITE_W),
        .SPRITE_H    (SPRITE_H),
        .TRANSPARENT (TRANSPARENT),
        .AW          (AW)
    ) u_rom (
        .clock  (clock),
        .i_addr (w_rom_addr),
        .o_data (w_rom_data)
    );

    // State register
    always_ff @(posedge clock) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // Request edge history, latched job, offset scan and the one-stage pixel pipeline
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_req_char <= 1'b0;
            r_req_bg   <= 1'b0;
            r_mode     <= MODE_CHAR;
            r_x        <= '0;
            r_y        <= '0;
            r_cx       <= '0;
            r_cy       <= '0;
            r_pv       <= 1'b0;
            r_pon      <= 1'b0;
            r_px       <= '0;
            r_py       <= '0;
        end else begin
            r_req_char <= drawChar;
            r_req_bg   <= drawBG;
            if (w_start) begin
                r_x    <= xCoordinate;
                r_y    <= yCoordinate;
                r_mode <= w_bg_rise ? MODE_BG : MODE_CHAR;
                r_cx   <= '0;
                r_cy   <= '0;
            end else if (r_state == S_DRAW) begin
                r_cx <= w_cx_end ? '0 : r_cx + CXW'(1);
                if (w_cx_end) r_cy <= r_cy + CYW'(1);
            end
            r_pv  <= r_state == S_DRAW;
            r_pon <= w_on;
            r_px  <= w_x[8:0];
            r_py  <= w_y[7:0];
        end
    end

    // Next state and outputs; the pixel stage pairs last cycle's offset with this cycle's ROM data
    always_comb begin
        w_next   = r_state;
        w_next   = (r_state == S_IDLE)  ? (w_start ? S_DRAW : S_IDLE) :
                   (r_state == S_DRAW)  ? (w_last ? S_FLUSH : S_DRAW) :
                   (r_state == S_FLUSH) ? S_DONE : S_IDLE;
        plot     = r_pv & r_pon & ((r_mode == MODE_BG) | (w_rom_data != TRANSPARENT));
        colour   = r_pv ? ((r_mode == MODE_BG) ? bg_data : w_rom_data) : '0;
        vga_x    = r_px;
        vga_y    = r_py;
        doneBG   = (r_state == S_DONE) & (r_mode == MODE_BG);
        doneChar = (r_state == S_DONE) & (r_mode == MODE_CHAR);
        bg_addr  = (r_state == S_DRAW) ?
                   (17'(w_y[7:0]) << 8) + (17'(w_y[7:0]) << 6) + 17'(w_x[8:0]) : '0;
    end
endmodule

// File: tb/tb_sprite_drawer.sv
// tb_sprite_drawer: directed vectors plus reset and movement-loop sequences for sprite_drawer
module tb_sprite_drawer;
    logic        clock = 1'b0;
    logic        resetn, drawChar, drawBG;
    logic [8:0]  xCoordinate;
    logic [7:0]  yCoordinate;
    logic        doneChar, doneBG, plot;
    logic [16:0] bg_addr;
    logic [8:0]  bg_data = '0;
    logic [8:0]  vga_x, colour;
    logic [7:0]  vga_y;
    int          n_checks = 0, n_fail = 0;

    typedef struct {
        bit rel;
        bit bg;
        bit chr;
        bit hold;
        int x;
        int y;
        int plots;
    } vec_t;

    sprite_drawer dut (
        .clock       (clock),
        .resetn      (resetn),
        .drawChar    (drawChar),
        .drawBG      (drawBG),
        .xCoordinate (xCoordinate),
        .yCoordinate (yCoordinate),
        .doneChar    (doneChar),
        .doneBG      (doneBG),
        .bg_addr     (bg_addr),
        .bg_data     (bg_data),
        .vga_x       (vga_x),
        .vga_y       (vga_y),
        .colour      (colour),
        .plot        (plot)
    );

    always #5 clock = ~clock;

    // External background ROM: one-cycle latency, colour is the low address bits
    always @(posedge clock) bg_data <= bg_addr[8:0];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Starts a draw in cycle 0 and watches 200 cycles of output
    task automatic run_vec(input string tag, input vec_t v);
        int plots = 0, perr = 0, done_cyc = -1, done_n = 0, other_n = 0;
        int cx, cy, px, py, ex;
        bit seen [8][8];
        foreach (seen[i, j]) seen[i][j] = 1'b0;
        if (v.rel) resetn = 1'b1;
        xCoordinate = 9'(v.x);
        yCoordinate = 8'(v.y);
        drawBG      = v.bg;
        drawChar    = v.chr;
        for (int c = 1; c <= 200; c++) begin
            tick();
            if (!v.hold) begin
                drawBG   = 1'b0;
                drawChar = 1'b0;
            end
            xCoordinate = 9'd7;
            yCoordinate = 8'd3;
            if (plot) begin
                plots++;
                px = int'(vga_x);
                py = int'(vga_y);
                cx = px - v.x;
                cy = py - v.y;
                if (c < 2 || c > 65 || cx < 0 || cx > 7 || cy < 0 || cy > 7 || px >= 320 || py >= 240)
                    perr++;
                else begin
                    if (seen[cy][cx]) perr++;
                    seen[cy][cx] = 1'b1;
                    ex = v.bg ? ((py * 320 + px) % 512) : (cx == 0 ? 511 : 64 + cy * 8 + cx);
                    if (int'(colour) != ex || (!v.bg && colour == 9'h1FF)) perr++;
                end
            end
            if (v.bg ? doneBG : doneChar) begin
                done_n++;
                done_cyc = c;
            end
            if (v.bg ? doneChar : doneBG) other_n++;
        end
        drawBG   = 1'b0;
        drawChar = 1'b0;
        repeat (3) tick();
        check({tag, " plots"}, plots, v.plots);
        check({tag, " pixel errors"}, perr, 0);
        check({tag, " done cycle"}, done_cyc, 66);
        check({tag, " done count"}, done_n, 1);
        check({tag, " wrong done"}, other_n, 0);
    endtask

    initial begin
        vec_t vt [9];
        vec_t vn;
        int   p, d, t_bg, t_ch, bgp, chp, cerr;
        vt[0] = '{1, 1, 0, 0, 10, 20, 64};
        vt[1] = '{0, 1, 0, 0, 95, 221, 64};
        vt[2] = '{0, 0, 1, 0, 120, 196, 56};
        vt[3] = '{0, 1, 0, 0, 316, 236, 16};
        vt[4] = '{0, 0, 1, 0, 316, 236, 12};
        vt[5] = '{0, 1, 0, 0, 319, 239, 1};
        vt[6] = '{0, 0, 1, 0, 0, 0, 56};
        vt[7] = '{0, 1, 1, 1, 40, 50, 64};
        vt[8] = '{0, 0, 1, 1, 200, 100, 56};

        resetn      = 1'b0;
        drawBG      = 1'b1;
        drawChar    = 1'b0;
        xCoordinate = 9'd10;
        yCoordinate = 8'd20;
        repeat (3) tick();
        check("reset plot", plot, 0);
        check("reset doneChar", doneChar, 0);
        check("reset doneBG", doneBG, 0);
        check("reset vga_x", vga_x, 0);
        check("reset vga_y", vga_y, 0);
        check("reset colour", colour, 0);
        check("reset bg_addr", bg_addr, 0);

        for (int i = 0; i < 9; i++) run_vec($sformatf("vec%0d", i), vt[i]);

        xCoordinate = 9'd50;
        yCoordinate = 8'd60;
        drawBG      = 1'b1;
        for (int c = 1; c <= 29; c++) begin
            tick();
            drawBG = 1'b0;
        end
        check("mid plot before reset", plot, 1);
        tick();
        resetn = 1'b0;
        tick();
        check("mid plot after reset", plot, 0);
        resetn = 1'b1;
        p = 0;
        d = 0;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (plot) p++;
            if (doneBG || doneChar) d++;
        end
        check("mid plots after abort", p, 0);
        check("mid done after abort", d, 0);
        vn = '{0, 1, 0, 0, 50, 60, 64};
        run_vec("after abort", vn);

        xCoordinate = 9'd100;
        yCoordinate = 8'd100;
        drawBG      = 1'b1;
        t_bg = -1;
        bgp  = 0;
        for (int c = 1; c <= 150 && t_bg < 0; c++) begin
            tick();
            if (plot) bgp++;
            if (doneBG) t_bg = c;
        end
        check("loop doneBG cycle", t_bg, 66);
        check("loop bg plots", bgp, 64);
        tick();
        drawBG      = 1'b0;
        xCoordinate = 9'd104;
        drawChar    = 1'b1;
        t_ch = -1;
        chp  = 0;
        cerr = 0;
        for (int c = 1; c <= 150 && t_ch < 0; c++) begin
            tick();
            if (plot) begin
                chp++;
                if (vga_x < 9'd105 || vga_x > 9'd111 || vga_y < 8'd100 || vga_y > 8'd107) cerr++;
            end
            if (doneBG) cerr++;
            if (doneChar) t_ch = c;
        end
        drawChar = 1'b0;
        repeat (3) tick();
        check("loop doneChar cycle", t_ch, 66);
        check("loop char plots", chp, 56);
        check("loop char errors", cerr, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
